// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: initiator side of the word-wide data memory port.
// Takes byte/half/word loads and stores from the core, drives word-indexed
// memory strobes, extracts and extends load data, and uses read-modify-write
// for sub-word stores because the memory accepts only full-word writes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (traps misaligned/illegal requests).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | req_ready=1, latch request on req_valid
// LOAD   | memory_read=1, extract/extend lane into response register
// RMW_RD | memory_read=1, merge store data into the word read back
// STORE  | memory_write=1 for one cycle with merged or full word
// RESP   | rsp_valid=1 for one cycle, then back to IDLE
module lsu_mem_initiator #(
   parameter int MEMORY_SIZE = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic        memory_read,
   output logic        memory_write,
   output logic [31:0] address,
   output logic [31:0] write_data,
   input  logic [31:0] read_data
);

   localparam logic [31:0] IDX_MASK = 32'(MEMORY_SIZE / 4 - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RMW_RD = 3'd2,
      STORE  = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic [31:0] addr_q;
   logic [31:0] wword_q;
   logic [31:0] rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        err_q;
`endif

   logic [1:0]  size_eff;
   logic [1:0]  lane_in;
   logic        req_err;
   logic [4:0]  shamt;
   logic [31:0] rd_shift;
   logic [31:0] load_ext;
   logic [31:0] mask;
   logic [31:0] ins;
   logic [31:0] merged;

   // Decode the incoming request: effective size, byte lane and trap condition.
   always_comb begin
      size_eff = req_size;
      lane_in  = req_addr[1:0];
      req_err  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      req_err = (req_size == 2'b11) ||
                ((req_size == 2'b01) && req_addr[0]) ||
                ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
      // Without trapping, illegal size acts as word and low address bits are ignored.
      if (req_size == 2'b11) begin
         size_eff = 2'b10;
      end
      if (size_eff == 2'b01) begin
         lane_in = {req_addr[1], 1'b0};
      end else if (size_eff == 2'b10) begin
         lane_in = 2'b00;
      end
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and strobes, decoded from the registered state only.
   always_comb begin
      state_d      = state_q;
      req_ready    = 1'b0;
      rsp_valid    = 1'b0;
      memory_read  = 1'b0;
      memory_write = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_err) begin
                  state_d = RESP;
               end else if (!req_write) begin
                  state_d = LOAD;
               end else if (size_eff == 2'b10) begin
                  state_d = STORE;
               end else begin
                  state_d = RMW_RD;
               end
            end
         end
         LOAD: begin
            memory_read = 1'b1;
            state_d     = RESP;
         end
         RMW_RD: begin
            memory_read = 1'b1;
            state_d     = STORE;
         end
         STORE: begin
            memory_write = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Lane extraction for loads and lane merge for sub-word stores.
   always_comb begin
      shamt    = {lane_q, 3'b000};
      rd_shift = read_data >> shamt;
      case (size_q)
         2'b00:   load_ext = uns_q ? {24'b0, rd_shift[7:0]}
                                   : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   load_ext = uns_q ? {16'b0, rd_shift[15:0]}
                                   : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: load_ext = read_data;
      endcase
      if (size_q == 2'b00) begin
         mask = 32'h0000_00FF << shamt;
         ins  = {24'b0, wdata_q[7:0]} << shamt;
      end else begin
         mask = 32'h0000_FFFF << shamt;
         ins  = {16'b0, wdata_q[15:0]} << shamt;
      end
      merged = (read_data & ~mask) | ins;
   end

   // Request latches, write word and response registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         lane_q  <= 2'b00;
         wdata_q <= 32'h0;
         addr_q  <= 32'h0;
         wword_q <= 32'h0;
         rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
         err_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  size_q  <= size_eff;
                  uns_q   <= req_unsigned;
                  lane_q  <= lane_in;
                  wdata_q <= req_wdata;
                  if (!req_err) begin
                     addr_q <= (req_addr >> 2) & IDX_MASK;
                  end
                  if (req_write && (size_eff == 2'b10)) begin
                     wword_q <= req_wdata;
                  end
`ifdef LSU_MISALIGN_TRAP_EN
                  if (req_err) begin
                     rdata_q <= 32'h0;
                     err_q   <= 1'b1;
                  end
`endif
               end
            end
            LOAD: begin
               rdata_q <= load_ext;
`ifdef LSU_MISALIGN_TRAP_EN
               err_q   <= 1'b0;
`endif
            end
            RMW_RD: begin
               wword_q <= merged;
            end
            STORE: begin
               rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
               err_q   <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

   assign address    = addr_q;
   assign write_data = wword_q;
   assign rsp_rdata  = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
   assign rsp_error  = err_q;
`else
   assign rsp_error  = 1'b0;
`endif

endmodule
